// File: rtl/cpu_pkg.sv
// Shared definitions for the single-bus CPU control path: opcodes, FSM states,
// instruction classes and the control-strobe bundle. Mul/div support is gated by CU_MULDIV_EN.
package cpu_pkg;

  localparam logic [4:0] OP_LD   = 5'd0;
  localparam logic [4:0] OP_LDI  = 5'd1;
  localparam logic [4:0] OP_ST   = 5'd2;
  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_SUB  = 5'd4;
  localparam logic [4:0] OP_AND  = 5'd5;
  localparam logic [4:0] OP_OR   = 5'd6;
  localparam logic [4:0] OP_SHR  = 5'd7;
  localparam logic [4:0] OP_SHRA = 5'd8;
  localparam logic [4:0] OP_SHL  = 5'd9;
  localparam logic [4:0] OP_ROR  = 5'd10;
  localparam logic [4:0] OP_ROL  = 5'd11;
  localparam logic [4:0] OP_ADDI = 5'd12;
  localparam logic [4:0] OP_ANDI = 5'd13;
  localparam logic [4:0] OP_ORI  = 5'd14;
  localparam logic [4:0] OP_MUL  = 5'd15;
  localparam logic [4:0] OP_DIV  = 5'd16;
  localparam logic [4:0] OP_NEG  = 5'd17;
  localparam logic [4:0] OP_NOT  = 5'd18;
  localparam logic [4:0] OP_BR   = 5'd19;
  localparam logic [4:0] OP_JR   = 5'd20;
  localparam logic [4:0] OP_IN   = 5'd22;
  localparam logic [4:0] OP_OUT  = 5'd23;
  localparam logic [4:0] OP_MFHI = 5'd24;
  localparam logic [4:0] OP_MFLO = 5'd25;
  localparam logic [4:0] OP_NOP  = 5'd26;
  localparam logic [4:0] OP_HALT = 5'd27;

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_STOP, S_HALT
  } state_e;

  typedef enum logic [3:0] {
    C_RTYPE, C_IMM, C_LDI, C_LD, C_ST, C_UNARY, C_BR, C_JR,
    C_IN, C_OUT, C_MFHI, C_MFLO, C_MULDIV, C_NOP, C_HALT, C_ILLEGAL
  } iclass_e;

  typedef struct packed {
    logic illegalOp;
    logic pcOut;
    logic incPc;
    logic pcIn;
    logic marIn;
    logic read;
    logic write;
    logic mdrIn;
    logic mdrOut;
    logic irIn;
    logic ryIn;
    logic rzIn;
    logic rzLoOut;
    logic rzHiOut;
    logic hiIn;
    logic loIn;
    logic hiOut;
    logic loOut;
    logic cOut;
    logic gra;
    logic grb;
    logic grc;
    logic rin;
    logic rout;
    logic baOut;
    logic portIn;
    logic portOut;
  } ctrl_t;

  // Classes whose whole execute phase fits in T3 (halt is handled separately).
  function automatic logic endsAtT3(iclass_e c);
    return (c == C_JR) || (c == C_IN) || (c == C_OUT) || (c == C_MFHI) ||
           (c == C_MFLO) || (c == C_NOP) || (c == C_ILLEGAL);
  endfunction

endpackage

// File: rtl/cu_decode.sv
// Combinational opcode-to-instruction-class decoder.
// With CU_MULDIV_EN undefined, mul/div decode as illegal.
module cu_decode
  import cpu_pkg::*;
#(
  parameter int OPW = 5
) (
  input  logic [OPW-1:0] opcode_i,
  output iclass_e        class_o
);

  always_comb begin
    class_o = C_ILLEGAL;
    case (opcode_i)
      OP_LD:                            class_o = C_LD;
      OP_LDI:                           class_o = C_LDI;
      OP_ST:                            class_o = C_ST;
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_SHR, OP_SHRA, OP_SHL,
      OP_ROR, OP_ROL:                   class_o = C_RTYPE;
      OP_ADDI, OP_ANDI, OP_ORI:         class_o = C_IMM;
`ifdef CU_MULDIV_EN
      OP_MUL, OP_DIV:                   class_o = C_MULDIV;
`else
      OP_MUL, OP_DIV:                   class_o = C_ILLEGAL;
`endif
      OP_NEG, OP_NOT:                   class_o = C_UNARY;
      OP_BR:                            class_o = C_BR;
      OP_JR:                            class_o = C_JR;
      OP_IN:                            class_o = C_IN;
      OP_OUT:                           class_o = C_OUT;
      OP_MFHI:                          class_o = C_MFHI;
      OP_MFLO:                          class_o = C_MFLO;
      OP_NOP:                           class_o = C_NOP;
      OP_HALT:                          class_o = C_HALT;
      default:                          class_o = C_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore control unit: fetch T0-T2, per-class execute T3-T7, run/stop and halt.
// Mul/div execute sequence is enabled by CU_MULDIV_EN (via cu_decode).
module control_unit
  import cpu_pkg::*;
#(
  parameter int OPW = 5
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] ir,
  input  logic        con,
  input  logic        stop,
  output logic        run,
  output logic        illegal_op,
  output logic        PCout,
  output logic        IncPC,
  output logic        PCin,
  output logic        MARin,
  output logic        Read,
  output logic        Write,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        RYin,
  output logic        RZin,
  output logic        RZLOout,
  output logic        RZHIout,
  output logic        HIin,
  output logic        LOin,
  output logic        HIout,
  output logic        LOout,
  output logic        Cout,
  output logic        gra,
  output logic        grb,
  output logic        grc,
  output logic        rin,
  output logic        rout,
  output logic        BAout,
  output logic        PORTin,
  output logic        PORTout
);

  state_e  state_q, state_d;
  iclass_e insnClass;
  ctrl_t   ctrl;
  logic    unusedIrBits;

  assign unusedIrBits = ^ir[31-OPW:0];

  cu_decode #(.OPW(OPW)) uDecode (
    .opcode_i (ir[31 -: OPW]),
    .class_o  (insnClass)
  );

  // Async clear puts the machine in RST at once, so Write and all strobes drop immediately.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state_q <= S_RST;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST:  state_d = stop ? S_STOP : S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   state_d = S_T2;
      S_T2:   state_d = S_T3;
      S_T3: begin
        if (insnClass == C_HALT)      state_d = S_HALT;
        else if (endsAtT3(insnClass)) state_d = stop ? S_STOP : S_T0;
        else                          state_d = S_T4;
      end
      S_T4:   state_d = (insnClass == C_UNARY) ? (stop ? S_STOP : S_T0) : S_T5;
      S_T5: begin
        if (insnClass == C_LD || insnClass == C_ST || insnClass == C_MULDIV) state_d = S_T6;
        else state_d = stop ? S_STOP : S_T0;
      end
      S_T6:   state_d = (insnClass == C_MULDIV) ? (stop ? S_STOP : S_T0) : S_T7;
      S_T7:   state_d = stop ? S_STOP : S_T0;
      S_STOP: state_d = stop ? S_STOP : S_T0;
      S_HALT: state_d = S_HALT;
      default: state_d = S_RST;
    endcase
  end

  // Strobes follow the state, refined by the IR class during execute and by con in br T5.
  always_comb begin
    ctrl = '0;
    run  = 1'b0;
    case (state_q)
      S_T0: begin
        run = 1'b1; ctrl.pcOut = 1'b1; ctrl.marIn = 1'b1; ctrl.incPc = 1'b1;
      end
      S_T1: begin
        run = 1'b1; ctrl.read = 1'b1; ctrl.mdrIn = 1'b1;
      end
      S_T2: begin
        run = 1'b1; ctrl.mdrOut = 1'b1; ctrl.irIn = 1'b1;
      end
      S_T3: begin
        run = 1'b1;
        case (insnClass)
          C_RTYPE, C_IMM: begin ctrl.grb = 1'b1; ctrl.rout = 1'b1; ctrl.ryIn = 1'b1; end
          C_LDI, C_LD, C_ST: begin ctrl.grb = 1'b1; ctrl.baOut = 1'b1; ctrl.ryIn = 1'b1; end
          C_UNARY:  begin ctrl.grb = 1'b1; ctrl.rout = 1'b1; ctrl.rzIn = 1'b1; end
          C_BR:     begin ctrl.pcOut = 1'b1; ctrl.ryIn = 1'b1; end
          C_JR:     begin ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.pcIn = 1'b1; end
          C_IN:     begin ctrl.portOut = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1; end
          C_OUT:    begin ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.portIn = 1'b1; end
          C_MFHI:   begin ctrl.hiOut = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1; end
          C_MFLO:   begin ctrl.loOut = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1; end
          C_MULDIV: begin ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.ryIn = 1'b1; end
          C_ILLEGAL: ctrl.illegalOp = 1'b1;
          default: ;
        endcase
      end
      S_T4: begin
        run = 1'b1;
        case (insnClass)
          C_RTYPE:  begin ctrl.grc = 1'b1; ctrl.rout = 1'b1; ctrl.rzIn = 1'b1; end
          C_IMM, C_LDI, C_LD, C_ST, C_BR: begin ctrl.cOut = 1'b1; ctrl.rzIn = 1'b1; end
          C_UNARY:  begin ctrl.rzLoOut = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1; end
          C_MULDIV: begin ctrl.grb = 1'b1; ctrl.rout = 1'b1; ctrl.rzIn = 1'b1; end
          default: ;
        endcase
      end
      S_T5: begin
        run = 1'b1;
        case (insnClass)
          C_RTYPE, C_IMM, C_LDI: begin ctrl.rzLoOut = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1; end
          C_LD, C_ST: begin ctrl.rzLoOut = 1'b1; ctrl.marIn = 1'b1; end
          C_BR:       begin ctrl.rzLoOut = con; ctrl.pcIn = con; end
          C_MULDIV:   begin ctrl.rzLoOut = 1'b1; ctrl.loIn = 1'b1; end
          default: ;
        endcase
      end
      S_T6: begin
        run = 1'b1;
        case (insnClass)
          C_LD:     begin ctrl.read = 1'b1; ctrl.mdrIn = 1'b1; end
          C_ST:     begin ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.mdrIn = 1'b1; end
          C_MULDIV: begin ctrl.rzHiOut = 1'b1; ctrl.hiIn = 1'b1; end
          default: ;
        endcase
      end
      S_T7: begin
        run = 1'b1;
        case (insnClass)
          C_LD: begin ctrl.mdrOut = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1; end
          C_ST: ctrl.write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign illegal_op = ctrl.illegalOp;
  assign PCout      = ctrl.pcOut;
  assign IncPC      = ctrl.incPc;
  assign PCin       = ctrl.pcIn;
  assign MARin      = ctrl.marIn;
  assign Read       = ctrl.read;
  assign Write      = ctrl.write;
  assign MDRin      = ctrl.mdrIn;
  assign MDRout     = ctrl.mdrOut;
  assign IRin       = ctrl.irIn;
  assign RYin       = ctrl.ryIn;
  assign RZin       = ctrl.rzIn;
  assign RZLOout    = ctrl.rzLoOut;
  assign RZHIout    = ctrl.rzHiOut;
  assign HIin       = ctrl.hiIn;
  assign LOin       = ctrl.loIn;
  assign HIout      = ctrl.hiOut;
  assign LOout      = ctrl.loOut;
  assign Cout       = ctrl.cOut;
  assign gra        = ctrl.gra;
  assign grb        = ctrl.grb;
  assign grc        = ctrl.grc;
  assign rin        = ctrl.rin;
  assign rout       = ctrl.rout;
  assign BAout      = ctrl.baOut;
  assign PORTin     = ctrl.portIn;
  assign PORTout    = ctrl.portOut;

endmodule

// File: doc/control_unit.md
# control_unit

Hardwired Moore control unit that sequences the single-bus CPU datapath through fetch and per-instruction execute steps. It reads the instruction register and branch-condition result and drives every register-enable, bus-select, memory and select/encode strobe of the datapath. One state is executed per clock. It also handles run/stop and halt.

## Interface
Parameters:
- `OPW`, 5: opcode width; the opcode is `ir[31:27]`.

Ports:
- `clock`  in  1  system clock; all state changes on the rising edge.
- `clear`  in  1  reset; asynchronous, active-low.
- `ir`  in  32  current IR contents.
- `con`  in  1  branch condition result for the current IR; valid from T3.
- `stop`  in  1  level request to pause at the next instruction boundary.
- `run`  out  1  high while the unit is fetching or executing.
- `illegal_op`  out  1  one-cycle pulse in T3 for an unknown opcode.
- `PCout`, `IncPC`, `PCin`, `MARin`  out  1 each  PC and MAR strobes.
- `Read`, `Write`, `MDRin`, `MDRout`, `IRin`  out  1 each  memory and IR strobes.
- `RYin`, `RZin`, `RZLOout`, `RZHIout`, `HIin`, `LOin`, `HIout`, `LOout`, `Cout`  out  1 each  ALU and HI/LO strobes.
- `gra`, `grb`, `grc`, `rin`, `rout`, `BAout`  out  1 each  controls for the select/encode logic.
- `PORTin`, `PORTout`  out  1 each  I/O port strobes.

## Operation
- The state register is the only storage. Outputs decode combinationally from state only; they never depend on the `ir` or `con` inputs except where stated.
- **Reset (`clear`=0):** state goes to RST immediately.
  - All strobes and `run` read 0.
  - After `clear` deasserts, RST lasts one cycle, then T0.
- **Fetch:**
  - T0: `PCout`, `MARin`, `IncPC`.
  - T1: `Read`, `MDRin`.
  - T2: `MDRout`, `IRin`.
  - T3: first execute step, chosen from `ir[31:27]`.
- **Opcodes:** ld 0, ldi 1, st 2, add 3, sub 4, and 5, or 6, shr 7, shra 8, shl 9, ror 10, rol 11, addi 12, andi 13, ori 14, mul 15, div 16, neg 17, not 18, br 19, jr 20, in 22, out 23, mfhi 24, mflo 25, nop 26, halt 27.
- **Execute sequences** (last listed step returns to T0):
  - R-type (3–11): T3 `grb rout RYin`; T4 `grc rout RZin`; T5 `RZLOout gra rin`.
  - Immediate (12–14) and ldi: T3 `grb rout RYin` (`BAout` instead of `rout` for ldi); T4 `Cout RZin`; T5 `RZLOout gra rin`.
  - ld: T3 `grb BAout RYin`; T4 `Cout RZin`; T5 `RZLOout MARin`; T6 `Read MDRin`; T7 `MDRout gra rin`.
  - st: T3–T5 as ld; T6 `gra rout MDRin` with `Read`=0; T7 `Write`.
  - neg/not: T3 `grb rout RZin`; T4 `RZLOout gra rin`.
  - br: T3 `PCout RYin`; T4 `Cout RZin`; T5 `RZLOout PCin` only if `con`=1. T5 is always occupied.
  - jr: T3 `gra rout PCin`.
  - in: T3 `PORTout gra rin`. out: T3 `gra rout PORTin`. mfhi/mflo: T3 `HIout`/`LOout gra rin`.
  - nop and unknown opcodes: T3 has no strobes and returns to T0; unknown opcodes also pulse `illegal_op`.
  - halt: go to HALT; `run`=0 and no strobes. Only `clear` exits HALT.
- **Stop:** `stop` is sampled on the transition into T0.
  - If `stop`=1, enter STOP instead (`run`=0, no strobes). STOP stays until `stop`=0, then goes to T0 on the next cycle.
  - A `stop` asserted mid-instruction never truncates the instruction.
- **Mutual exclusion:** at most one bus-driving strobe (`*out`, `rout`, `BAout`) is high in any state.

## Timing
- Instruction latency (T0 to the next T0): R-type/immediate/ldi/br 6 cycles, ld/st 8, neg/not 5, single-step ops 4.
- RAM is synchronous. The `Read` step precedes the `MDRout` step by exactly one cycle.
- `clear` asserted in any state, including mid-store, forces RST in the same cycle. `Write` drops asynchronously.

## Configuration
- `CU_MULDIV_EN` defined: mul/div execute as T3 `gra rout RYin`; T4 `grb rout RZin`; T5 `RZLOout LOin`; T6 `RZHIout HIin`; 7 cycles total.
- `CU_MULDIV_EN` undefined: opcodes 15/16 are handled as unknown (`illegal_op` pulse, nop timing). No T6 is reached for these opcodes.

## Structure
- Shared package `cpu_pkg` holds:
  - the opcode constants;
  - the state enum: RST, T0–T7, STOP, HALT;
  - the instruction-class enum: RTYPE, IMM, LDI, LD, ST, UNARY, BR, JR, IN, OUT, MFHI, MFLO, MULDIV, NOP, HALT, ILLEGAL.
- One sub-module, `cu_decode`, is purely combinational: opcode → instruction class.
- `control_unit` contains the state register, the next-state logic and the output decode.

## Test plan
- Reset release, then `ir`=add (opcode 3) → states RST, T0, T1, T2, T3, T4, T5, T0. Check `RYin` in T3, `RZin` in T4, `rin` in T5.
- `ir`=ld (0) → T0–T7. Check `Read` in T1 and T6, `MDRout gra rin` in T7, and the next T0 at cycle 8.
- `ir`=br (19) with `con`=0, then `con`=1 → `PCin` in T5 only in the second case. Both take 6 cycles.
- `stop`=1 during T4 of an add → T5 completes, enter STOP with `run`=0. Release `stop` → T0 one cycle later. Then `ir`=halt (27) → HALT held 20 cycles until `clear`.
- `clear` low during T7 of st → `Write`=0 within the same cycle, and all outputs read 0.
- `ir`=mul (15): with `CU_MULDIV_EN`, `LOin` in T5 and `HIin` in T6; without it, `illegal_op`=1 in T3 and return to T0.
